counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH SHALL exist: default 4, counter bit width, legal range 2..32.
REQ-002 Port clock SHALL be: input, 1 bit, single clock, rising-edge active.
REQ-003 Port reset SHALL be: input, 1 bit, asynchronous, active-high reset.
REQ-004 Port enable SHALL be: input, 1 bit, count enable sampled on the rising clock edge.
REQ-005 Port counter_out SHALL be: output, WIDTH bits, registered count value.
REQ-006 Port order SHALL be clock, reset, enable, counter_out, so that positional instantiation works; the optional port from REQ-017 follows last.
REQ-007 The block SHALL use one clock; reset SHALL be asynchronous and active-high, as already decided.

Function
REQ-008 On a rising clock edge with reset low and enable high, counter_out SHALL become counter_out+1 modulo 2^WIDTH.
REQ-009 On a rising clock edge with reset low and enable low, counter_out SHALL hold its value.
REQ-010 Wrap-around: at all-ones with enable high, counter_out SHALL become 0 on the next edge, with no stall and no saturation.
REQ-011 Latency: the first enabled edge SHALL produce counter_out=1 from 0, with the increment visible immediately after that edge (one-cycle latency).
REQ-012 Enable changes between edges SHALL have no effect; only the value at the rising edge matters.
REQ-013 counter_out SHALL be driven directly from a flop, with no combinational path from enable or reset to the output other than the asynchronous clear.

Reset
REQ-014 Asserting reset SHALL clear counter_out to 0 immediately, without waiting for a clock edge.
REQ-015 While reset is high, counter_out SHALL stay 0 regardless of enable or clock; reset dominates enable.
REQ-016 After reset deasserts, counting SHALL resume on the first rising edge where enable is high; reset mid-count SHALL discard the count.

Configuration
REQ-017 When macro COUNTER_WRAP_FLAG_EN is defined, a 1-bit output wrap SHALL be added; wrap is a registered pulse, high for exactly one cycle after the edge on which counter_out went from all-ones to 0, and cleared asynchronously by reset.
REQ-018 When COUNTER_WRAP_FLAG_EN is undefined, the wrap port and its logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-019 A shared package counter_pkg SHALL hold the default-width constant (4) and a count-type typedef parameterised from it.
REQ-020 One sub-module, counter_reg, SHALL be used: a WIDTH-bit register with asynchronous active-high clear and load-enable; the increment logic lives in counter.
REQ-021 Simulation-only assertions SHALL check: counter_out==0 whenever reset is high; hold when enable is low; +1 modulo 2^WIDTH when enable is high.

Verification
REQ-022 Power-up with reset=1 at t=5 and reset=0 at t=15, enable=0 throughout -> counter_out=0 from the reset assertion onward, with no change on clock edges.
REQ-023 Enable=1 for exactly 10 rising edges (10 ns clock, enable from t=25 to t=125) -> counter_out steps 1,2,...,10 and ends at 4'hA.
REQ-024 After the previous step, enable=0 over further edges -> counter_out holds 4'hA.
REQ-025 Enable=1 for 16 edges from 4'hF -> counter_out goes 0,1,...,F; with COUNTER_WRAP_FLAG_EN defined, wrap pulses for exactly one cycle after the F->0 edge.
REQ-026 Reset asserted between edges while counter_out=4'h7 and enable=1 -> counter_out=0 immediately, stays 0 while reset is high, then reaches 1 on the first enabled edge after release.
REQ-027 WIDTH=8, enable=1 for 256 edges from 0 -> counter_out returns to 8'h00, with no intermediate skips.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_pkg                                                  |
// | Description : Shared width constant and count type for the counter slice.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_reg                                                  |
// | Description : WIDTH-bit register, async active-high clear, load enable.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module counter_reg
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : counter_reg
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter                                                      |
// | Description : Enabled modulo-2^WIDTH up-counter. Defining                  |
// |               COUNTER_WRAP_FLAG_EN adds a registered one-cycle wrap pulse. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out
`ifdef COUNTER_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] next_count;

  assign next_count = counter_out + ONE;

  counter_reg #(
    .WIDTH (WIDTH)
  ) u_counter_reg (
    .clock (clock),
    .reset (reset),
    .load  (enable),
    .d     (next_count),
    .q     (counter_out)
  );

`ifdef COUNTER_WRAP_FLAG_EN
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Pulse follows the edge that rolled all-ones over to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= enable && (counter_out == ALL_ONES);
    end
  end
`endif

`ifndef SYNTHESIS
  logic [WIDTH-1:0] chk_prev;
  logic             chk_en;
  logic             chk_valid;

  // Compare each pre-edge value with the prediction made one edge earlier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chk_valid <= 1'b0;
      chk_prev  <= '0;
      chk_en    <= 1'b0;
    end else begin
      if (chk_valid) begin
        assert (counter_out == (chk_en ? chk_prev + ONE : chk_prev));
      end
      chk_valid <= 1'b1;
      chk_prev  <= counter_out;
      chk_en    <= enable;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      assert (counter_out == '0);
    end
  end
`endif

endmodule : counter
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_counter                                                   |
// | Description : Self-checking bench for counter (WIDTH 4 and WIDTH 8).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_counter;
  import counter_pkg::*;

  typedef struct {
    logic   rst;
    logic   en;
    count_t cnt;
    logic   wrp;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       wrp;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] counter_out;
  logic       reset8;
  logic       enable8;
  logic [7:0] counter_out8;
`ifdef COUNTER_WRAP_FLAG_EN
  logic       wrap;
  logic       wrap8;
`endif

  int   tests  = 0;
  int   failed = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  counter dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out)
`ifdef COUNTER_WRAP_FLAG_EN
    ,
    .wrap        (wrap)
`endif
  );

  counter #(
    .WIDTH (8)
  ) dut8 (
    .clock       (clock),
    .reset       (reset8),
    .enable      (enable8),
    .counter_out (counter_out8)
`ifdef COUNTER_WRAP_FLAG_EN
    ,
    .wrap        (wrap8)
`endif
  );

  // Rising edges at 10, 20, 30 ... ns; falling edges at 15, 25 ... ns.
  initial begin
    clock = 1'b0;
    #10;
    forever begin
      clock = 1'b1;
      #5;
      clock = 1'b0;
      #5;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, expect, compare after the next rising edge.
  task automatic step(input logic r, input logic e, input count_t c, input logic w);
    exp_t x;
    reset  = r;
    enable = e;
    exp_q.push_back('{8'(c), w});
    @(posedge clock);
    #1;
    x = exp_q.pop_front();
    check("count", 32'(counter_out), 32'(x.cnt));
`ifdef COUNTER_WRAP_FLAG_EN
    check("wrap", 32'(wrap), 32'(x.wrp));
`endif
    @(negedge clock);
  endtask

  initial begin
    exp_t x8;
    reset   = 1'b0;
    enable  = 1'b0;
    reset8  = 1'b1;
    enable8 = 1'b0;

    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0});
    for (int i = 1; i <= 10; i++) vecs.push_back('{1'b0, 1'b1, count_t'(i), 1'b0});
    for (int i = 0; i < 3; i++)   vecs.push_back('{1'b0, 1'b0, 4'hA, 1'b0});
    for (int i = 11; i <= 15; i++) vecs.push_back('{1'b0, 1'b1, count_t'(i), 1'b0});
    for (int i = 0; i < 16; i++)  vecs.push_back('{1'b0, 1'b1, count_t'(i), (i == 0)});
    vecs.push_back('{1'b0, 1'b0, 4'hF, 1'b0});

    // Power-up: reset at 5 ns clears without a clock edge.
    #5 reset = 1'b1;
    #1;
    check("reset_async", 32'(counter_out), 32'h0);
    check("reset8_state", 32'(counter_out8), 32'h0);
`ifdef COUNTER_WRAP_FLAG_EN
    check("reset_wrap", 32'(wrap), 32'h0);
`endif
    @(posedge clock);
    #1;
    check("reset_edge", 32'(counter_out), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].wrp);

    // Enable pulses between edges must be ignored.
    #1 enable = 1'b1;
    #1 enable = 1'b0;
    step(1'b0, 1'b0, 4'hF, 1'b0);
    enable = 1'b1;
    #1 enable = 1'b0;
    #1 enable = 1'b1;
    step(1'b0, 1'b1, 4'h0, 1'b1);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, count_t'(i), 1'b0);

    // Mid-cycle reset at count 7 with enable still high.
    #2 reset = 1'b1;
    #1;
    check("reset_midcount", 32'(counter_out), 32'h0);
    @(posedge clock);
    #1;
    check("reset_dominates", 32'(counter_out), 32'h0);
    @(negedge clock);
    step(1'b1, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h1, 1'b0);

    // 8-bit instance: full lap of 256 enabled edges.
    reset8  = 1'b0;
    enable8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{8'((i + 1) % 256), 1'b0});
      @(posedge clock);
      #1;
      x8 = exp_q.pop_front();
      check("count8", 32'(counter_out8), 32'(x8.cnt));
      @(negedge clock);
    end
    check("count8_final", 32'(counter_out8), 32'h00);
`ifdef COUNTER_WRAP_FLAG_EN
    check("wrap8_final", 32'(wrap8), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_counter
`default_nettype wire
